// File: rtl/fp8_div_if.sv
// Operand and result handshake bundle for the fp8 divider.
interface fp8_div_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [4:0] flags;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/fp8_div.sv
// Iterative fp8 divider: restoring division, one quotient bit per edge,
// round-to-nearest-even, special operands resolved at acceptance.
module fp8_div #(
  parameter int BIAS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  fp8_div_if.slave   io
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_PACK, S_DONE} state_t;

  state_t            state_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [7:0]        result_q;
  logic [4:0]        flags_q;
  logic              sign_q;
  logic [5:0]        rem_q;
  logic [4:0]        div_q;
  logic signed [4:0] exp_diff_q;
  logic [7:0]        q_q;
  logic [2:0]        cnt_q;

  logic              a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;
  logic              spec_s;
  logic [6:0]        spec_res_s;
  logic [4:0]        spec_flags_s;
  logic signed [4:0] exp_diff_s;

  logic              ge_s;
  logic [5:0]        sub_s;

  logic [3:0]        pk_mant_s;
  logic              pk_g_s, pk_r_s, pk_s_s, pk_rnd_s, pk_ovf_s, pk_unf_s;
  logic signed [4:0] pk_e_s;
  logic [7:0]        pk_result_s;
  logic [4:0]        pk_flags_s;

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.result    = result_q;
  assign io.flags     = flags_q;

  // Classify operands and pick the special-case outcome, if any.
  always_comb begin
    a_nan_s      = (io.a[6:4] == 3'd7) && (io.a[3:0] != 4'h0);
    b_nan_s      = (io.b[6:4] == 3'd7) && (io.b[3:0] != 4'h0);
    a_inf_s      = (io.a[6:4] == 3'd7) && (io.a[3:0] == 4'h0);
    b_inf_s      = (io.b[6:4] == 3'd7) && (io.b[3:0] == 4'h0);
    a_zero_s     = (io.a[6:0] == 7'h00);
    b_zero_s     = (io.b[6:0] == 7'h00);
    exp_diff_s   = 5'({2'b00, io.a[6:4]}) - 5'({2'b00, io.b[6:4]}) + 5'(BIAS);
    spec_s       = 1'b1;
    spec_res_s   = 7'h00;
    spec_flags_s = 5'b00000;
    if (a_nan_s || b_nan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
      spec_res_s   = 7'h7F;
      spec_flags_s = 5'b10000;
    end else if (a_inf_s) begin
      spec_res_s   = 7'h70;
    end else if (b_zero_s) begin
      spec_res_s   = 7'h70;
      spec_flags_s = 5'b01000;
    end else if (b_inf_s || a_zero_s) begin
      spec_res_s   = 7'h00;
    end else begin
      spec_s       = 1'b0;
    end
  end

  assign ge_s  = (rem_q >= {1'b0, div_q});
  assign sub_s = rem_q - {1'b0, div_q};

  // Normalise, round to nearest even and range-check the finished quotient.
  always_comb begin
    if (q_q[7]) begin
      pk_mant_s = q_q[6:3];
      pk_g_s    = q_q[2];
      pk_r_s    = q_q[1];
      pk_s_s    = q_q[0] | (rem_q != 6'd0);
      pk_e_s    = exp_diff_q;
    end else begin
      pk_mant_s = q_q[5:2];
      pk_g_s    = q_q[1];
      pk_r_s    = q_q[0];
      pk_s_s    = (rem_q != 6'd0);
      pk_e_s    = exp_diff_q - 5'sd1;
    end
    pk_rnd_s = pk_g_s & (pk_r_s | pk_s_s | pk_mant_s[0]);
    if (pk_rnd_s && (pk_mant_s == 4'hF)) begin
      pk_mant_s = 4'h0;
      pk_e_s    = pk_e_s + 5'sd1;
    end else if (pk_rnd_s) begin
      pk_mant_s = pk_mant_s + 4'h1;
    end else begin
      pk_mant_s = pk_mant_s;
    end
    pk_ovf_s = (pk_e_s > 5'sd6);
    pk_unf_s = (pk_e_s < 5'sd0);
    if (pk_ovf_s) begin
      pk_result_s = {sign_q, 7'h70};
    end else if (pk_unf_s) begin
      pk_result_s = {sign_q, 7'h00};
    end else begin
      pk_result_s = {sign_q, pk_e_s[2:0], pk_mant_s};
    end
    pk_flags_s = {1'b0, 1'b0, pk_ovf_s, pk_unf_s,
                  pk_g_s | pk_r_s | pk_s_s | pk_ovf_s | pk_unf_s};
  end

  // Control FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= 8'h00;
      flags_q     <= 5'b00000;
      sign_q      <= 1'b0;
      rem_q       <= 6'd0;
      div_q       <= 5'd0;
      exp_diff_q  <= 5'sd0;
      q_q         <= 8'h00;
      cnt_q       <= 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (io.in_valid) begin
            sign_q     <= io.a[7] ^ io.b[7];
            in_ready_q <= 1'b0;
            if (spec_s) begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              result_q    <= {io.a[7] ^ io.b[7], spec_res_s};
              flags_q     <= spec_flags_s;
            end else begin
              state_q    <= S_CALC;
              rem_q      <= {2'b01, io.a[3:0]};
              div_q      <= {1'b1, io.b[3:0]};
              exp_diff_q <= exp_diff_s;
              q_q        <= 8'h00;
              cnt_q      <= 3'd0;
            end
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        S_CALC: begin
          // Remainder always stays below 2*D, so the shifted value fits 6 bits.
          q_q   <= {q_q[6:0], ge_s};
          rem_q <= ge_s ? (sub_s << 1) : (rem_q << 1);
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_q <= S_PACK;
          end else begin
            state_q <= S_CALC;
          end
        end
        S_PACK: begin
          result_q    <= pk_result_s;
          flags_q     <= pk_flags_s;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp8_div.sv
// Directed-vector bench for fp8_div: reset, normal, special, range and backpressure cases.
module tb_fp8_div;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  fp8_div_if bus ();

  fp8_div #(.BIAS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; issues one operation, checks latency, result, flags and handshake.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_res, input logic [4:0] exp_flags,
                        input int exp_lat);
    int lat;
    chk_eq({tag, "_in_ready"}, 16'(bus.in_ready), 16'd1);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk_eq({tag, "_latency"}, 16'(lat), 16'(exp_lat));
    chk_eq({tag, "_result"}, 16'(bus.result), 16'(exp_res));
    chk_eq({tag, "_flags"}, 16'(bus.flags), 16'(exp_flags));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk_eq({tag, "_out_valid_clr"}, 16'(bus.out_valid), 16'd0);
  endtask

  initial begin
    int lat;
    clk           = 1'b0;
    rst_n         = 1'b0;
    n_checks      = 0;
    n_pass        = 0;
    bus.in_valid  = 1'b0;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk_eq("rst_out_valid", 16'(bus.out_valid), 16'd0);
    chk_eq("rst_in_ready", 16'(bus.in_ready), 16'd1);
    chk_eq("rst_result", 16'(bus.result), 16'h00);
    chk_eq("rst_flags", 16'(bus.flags), 16'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a CALC sequence.
    bus.a = 8'h48; bus.b = 8'h40; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk_eq("midcalc_busy", 16'(bus.in_ready), 16'd0);
    rst_n = 1'b0;
    #1;
    chk_eq("midrst_out_valid", 16'(bus.out_valid), 16'd0);
    chk_eq("midrst_result", 16'(bus.result), 16'h00);
    chk_eq("midrst_flags", 16'(bus.flags), 16'h00);
    chk_eq("midrst_in_ready", 16'(bus.in_ready), 16'd1);
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid) lat++;
    end
    chk_eq("abandoned_no_output", 16'(lat), 16'd0);
    run_op("one_by_one", 8'h30, 8'h30, 8'h30, 5'b00000, 10);

    // Normal path.
    run_op("3_div_2", 8'h48, 8'h40, 8'h38, 5'b00000, 10);
    run_op("neg3_div_2", 8'hC8, 8'h40, 8'hB8, 5'b00000, 10);
    run_op("1_div_1p5", 8'h30, 8'h38, 8'h25, 5'b00001, 10);

    // Special operands.
    run_op("x_div_0", 8'h30, 8'h00, 8'h70, 5'b01000, 1);
    run_op("0_div_0", 8'h00, 8'h00, 8'h7F, 5'b10000, 1);
    run_op("inf_div_inf", 8'h70, 8'hF0, 8'hFF, 5'b10000, 1);
    run_op("x_div_inf", 8'h30, 8'h70, 8'h00, 5'b00000, 1);
    run_op("inf_div_x", 8'hF0, 8'h30, 8'hF0, 5'b00000, 1);
    run_op("0_div_x", 8'h00, 8'hB0, 8'h80, 5'b00000, 1);
    run_op("nan_div_x", 8'h31, 8'h7A, 8'h7F, 5'b10000, 1);

    // Range limits.
    run_op("overflow", 8'h6F, 8'h01, 8'h70, 5'b00101, 10);
    run_op("underflow", 8'h01, 8'h60, 8'h00, 5'b00011, 10);

    // Backpressure: hold DONE while new operands are offered.
    bus.a = 8'h48; bus.b = 8'h40; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.a = 8'h30; bus.b = 8'h00;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk_eq("bp_latency", 16'(lat), 16'd10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_eq("bp_out_valid", 16'(bus.out_valid), 16'd1);
      chk_eq("bp_result", 16'(bus.result), 16'h38);
      chk_eq("bp_flags", 16'(bus.flags), 16'h00);
      chk_eq("bp_in_ready", 16'(bus.in_ready), 16'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk_eq("bp_release_in_ready", 16'(bus.in_ready), 16'd1);
    chk_eq("bp_release_out_valid", 16'(bus.out_valid), 16'd0);
    chk_eq("bp_result_held", 16'(bus.result), 16'h38);
    run_op("back_to_back", 8'hC8, 8'h40, 8'hB8, 5'b00000, 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fp8_div.md
Name: fp8_div

Overview:
- Iterative divider for the 8-bit float format used by the fp8 arithmetic blocks.
  - Format: sign[7], exp[6:4], mant[3:0]; bias 3; hidden leading 1.
  - exp=7: inf when mant=0, NaN otherwise.
  - exp=0 with mant=0: zero. exp=0 with mant≠0 is a normal value (hidden 1).
- Computes a/b using restoring division, one quotient bit per cycle, with round-to-nearest-even.
- Counterpart of the fp8 multiplier; uses the same encoding, special-value rules and flag vector.
- Valid/ready handshake on both sides.

Parameters:
BIAS, 3, exponent bias; the datapath and tests assume 3.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a, b valid
in_ready  output  1  block can accept operands; equals (state==IDLE)
a  input  8  dividend {sign, exp[2:0], mant[3:0]}
b  input  8  divisor, same encoding
out_valid  output  1  result and flags valid
out_ready  input  1  consumer accepts the result
result  output  8  quotient, same encoding
flags  output  5  {invalid, div_by_zero, overflow, underflow, inexact}

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, out_valid=0, result=0x00, flags=0, iteration counter=0.
  - in_ready reads 1.
  - Any operation in progress is abandoned; nothing is emitted for it.
- FSM states: IDLE, CALC, PACK, DONE.
- IDLE:
  - Operands are accepted on an edge with in_valid=1 (in_ready is 1 in IDLE).
  - sign = a.sign ^ b.sign, latched at acceptance.
- Special cases, decided at acceptance; they go straight to DONE (out_valid high 1 edge after acceptance):
  - a or b NaN, 0/0, or inf/inf -> {sign,7,0xF}, flags=10000.
  - Finite nonzero / 0 -> {sign,7,0x0}, flags=01000.
  - inf / finite (including 0) -> {sign,7,0x0}, flags=00000.
  - Finite / inf, or 0 / finite nonzero -> {sign,0,0x0}, flags=00000.
- Normal path, IDLE->CALC:
  - Load R={1,a.mant} (6-bit), D={1,b.mant}.
  - Load exp_diff = a.exp - b.exp + BIAS as signed 5-bit.
  - Clear the 8-bit quotient q and count=0.
- CALC, one iteration per edge, 8 edges (count 0..7):
  - If R>=D: shift 1 into q and set R=(R-D)<<1.
  - Else: shift 0 into q and set R=R<<1.
  - q fills MSB-first: q[7] has weight 2^0, q[0] has weight 2^-7.
  - On count==7, go to PACK.
- PACK, one edge:
  - If q[7]=1: mant=q[6:3], g=q[2], r=q[1], s=q[0]|(R!=0), e=exp_diff.
  - Else: mant=q[5:2], g=q[1], r=q[0], s=(R!=0), e=exp_diff-1.
  - round_up = g & (r | s | mant[0]).
  - If mant=0xF and round_up: mant=0, e=e+1.
  - overflow = e>6 -> {sign,7,0x0}.
  - underflow = e<0 -> {sign,0,0x0}.
  - Otherwise the result is {sign,e[2:0],mant}.
  - inexact = g|r|s|overflow|underflow.
  - Register result and flags, then go to DONE.
- Latency: normal path out_valid rises 10 edges after the accepting edge (1 load + 8 CALC + 1 PACK).
- DONE:
  - out_valid=1; result and flags are held stable while out_ready=0.
  - On an edge with out_ready=1: out_valid=0 and state goes to IDLE.
  - No new operand is accepted in the same edge.
  - A result is never dropped or overwritten.
- in_ready is 0 in CALC, PACK and DONE; in_valid is ignored there.
- result and flags keep their last value after the handshake until the next result is registered.

Test Plan:
- Reset with rst_n=0 mid-CALC (a=0x48, b=0x40) -> out_valid=0, result=0x00, flags=0, in_ready=1. After release, 0x30/0x30 -> result=0x30, flags=00000, out_valid exactly 10 edges after accept.
- 0x48/0x40 (3.0/2.0) -> 0x38. 0xC8/0x40 -> 0xB8. Both with flags=00000.
- 0x30/0x38 (1.0/1.5) -> 0x25 (normalise path, e=2), flags=00001.
- Specials, each with out_valid 1 edge after accept:
  - 0x30/0x00 -> 0x70, flags=01000.
  - 0x00/0x00 -> 0x7F, flags=10000.
  - 0x70/0xF0 -> 0xFF, flags=10000.
  - 0x30/0x70 -> 0x00, flags=00000.
- Range limits:
  - 0x6F/0x01 -> 0x70, flags=00101 (overflow).
  - 0x01/0x60 -> 0x00, flags=00011 (underflow).
- Backpressure: out_ready=0 for 5 cycles after out_valid -> result/flags stable, in_ready=0, new in_valid ignored. After out_ready=1: in_ready=1 on the next cycle, and a back-to-back op completes correctly.
